// File: rtl/float_normalize_round.sv
// -----------------------------------------------------------------------------
// float_normalize_round
//   Back end of the FP adder datapath. Takes an unpacked, unnormalized sum and
//   returns a packed IEEE-754 value {sign, exp, frac}. The steps are normalize
//   (one shift per clock), round-to-nearest-even, then classify. Only one
//   operation is in flight at a time.
//
//   Ports
//     clock, resetN         rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready     operand handshake (ready only while idle)
//     in_sign               result sign
//     in_exp                signed biased exponent (EXPBITS+2 bits, 2's compl.)
//     in_mant               {carry, hidden, frac[FRACBITS-1:0], G, R, S}
//     in_nan / in_inf       force quiet NaN / signed infinity (NaN wins)
//     out_valid/out_ready   result handshake, result held until accepted
//     out_float            packed {sign, exp, frac}
//     out_ovf/unf/inx       overflow, underflow (tiny and inexact), inexact
//
//   float_normalize_round_chk flags a NORM phase that runs longer than
//   MB + 2**EXPBITS cycles.
// -----------------------------------------------------------------------------
module float_normalize_round_chk #(
    parameter int CW    = 10,
    parameter int BOUND = 284
) (
    input logic          clock,
    input logic          resetN,
    input logic          in_norm_i,
    input logic [CW-1:0] norm_cnt_i
);
    localparam logic [CW-1:0] BOUND_C = CW'(BOUND);

    // Normalization has to finish within BOUND cycles of entering NORM
    norm_bound_a: assert property (@(posedge clock) disable iff (!resetN)
                                   (in_norm_i |-> (norm_cnt_i < BOUND_C)));
endmodule

module float_normalize_round #(
    parameter int EXPBITS  = 8,
    parameter int FRACBITS = 23
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sign,
    input  logic [EXPBITS+1:0]         in_exp,
    input  logic [FRACBITS+4:0]        in_mant,
    input  logic                       in_nan,
    input  logic                       in_inf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXPBITS+FRACBITS:0]  out_float,
    output logic                       out_ovf,
    output logic                       out_unf,
    output logic                       out_inx
);
    localparam int MB    = FRACBITS + 5;             // internal mantissa width
    localparam int EW    = EXPBITS + 3;              // exponent plus headroom for +1 steps
    localparam int FW    = 1 + EXPBITS + FRACBITS;   // packed float width
    localparam int SW    = FRACBITS + 2;             // rounded significand incl. carry-out
    localparam int BOUND = MB + int'(32'd1 << EXPBITS);
    localparam int CW    = $clog2(BOUND) + 1;

    localparam logic signed [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] EXP_MAX = {3'b000, {EXPBITS{1'b1}}};
    localparam logic [FW-1:0]        QNAN_C  = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(FRACBITS-1){1'b0}}};
    localparam logic [CW-1:0]        CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0]        CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [MB-1:0]          mant_q;
    logic [CW-1:0]          norm_cnt_q;
    logic [FW-1:0]          out_float_q;
    logic                   ovf_q, unf_q, inx_q;

    logic                   in_ready_s, out_valid_s;
    logic                   special_s, mant_zero_s;
    logic signed [EW-1:0]   exp_in_s;
    logic                   carry_s, hidden_s, rsh_s, lsh_s, norm_done_s;
    logic [MB-1:0]          mant_rsh_s, mant_lsh_s;
    logic                   up_s;
    logic [SW-1:0]          sum_s;
    logic [FRACBITS:0]      sig_s;
    logic signed [EW-1:0]   exp_r_s;
    logic [EXPBITS-1:0]     field_s;
    logic [FW-1:0]          float_r_s;
    logic                   ovf_r_s, unf_r_s, inx_r_s;

    assign mant_zero_s = (in_mant == {MB{1'b0}});
    assign special_s   = in_nan | in_inf | mant_zero_s;
    assign exp_in_s    = {in_exp[EXPBITS+1], in_exp};

    // Normalization step decode: right shifts (carry, then denormal range) beat left shifts
    always_comb begin
        carry_s     = mant_q[MB-1];
        hidden_s    = mant_q[MB-2];
        rsh_s       = 1'b0;
        lsh_s       = 1'b0;
        if (carry_s || (exp_q < EXP_ONE)) begin
            rsh_s = 1'b1;
        end else if (!hidden_s && (exp_q > EXP_ONE)) begin
            lsh_s = 1'b1;
        end else begin
            rsh_s = 1'b0;
            lsh_s = 1'b0;
        end
        norm_done_s = !rsh_s && !lsh_s;
        // the bit leaving on the right folds into sticky
        mant_rsh_s  = {1'b0, mant_q[MB-1:1]} | {{(MB-1){1'b0}}, mant_q[0]};
        mant_lsh_s  = {mant_q[MB-2:0], 1'b0};
    end

    // Round-to-nearest-even, renormalize on carry-out, then classify the result
    always_comb begin
        up_s    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        sum_s   = {1'b0, mant_q[MB-2:3]} + {{(SW-1){1'b0}}, up_s};
        inx_r_s = |mant_q[2:0];
        field_s = {EXPBITS{1'b0}};
        if (sum_s[SW-1]) begin
            // carry-out only happens from all-ones, so the dropped bit is zero
            sig_s   = sum_s[SW-1:1];
            exp_r_s = exp_q + EXP_ONE;
        end else begin
            sig_s   = sum_s[SW-2:0];
            exp_r_s = exp_q;
        end
        ovf_r_s = (exp_r_s >= EXP_MAX);
        if (ovf_r_s) begin
            float_r_s = {sign_q, {EXPBITS{1'b1}}, {FRACBITS{1'b0}}};
            unf_r_s   = 1'b0;
            inx_r_s   = 1'b1;
        end else begin
            // hidden bit still clear means NORM stopped at exp==1: denormal or zero
            field_s   = sig_s[FRACBITS] ? exp_r_s[EXPBITS-1:0] : {EXPBITS{1'b0}};
            float_r_s = {sign_q, field_s, sig_s[FRACBITS-1:0]};
            unf_r_s   = (field_s == {EXPBITS{1'b0}}) & inx_r_s;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; special operands skip straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = special_s ? S_DONE : S_NORM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
                if (norm_done_s) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the registered state only
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_s  = 1'b1;
            S_DONE:  out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath: capture operand, shift during NORM, register rounded result
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sign_q      <= 1'b0;
            exp_q       <= {EW{1'b0}};
            mant_q      <= {MB{1'b0}};
            norm_cnt_q  <= {CW{1'b0}};
            out_float_q <= {FW{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        exp_q      <= exp_in_s;
                        mant_q     <= in_mant;
                        norm_cnt_q <= {CW{1'b0}};
                        if (special_s) begin
                            ovf_q <= 1'b0;
                            unf_q <= 1'b0;
                            inx_q <= 1'b0;
                        end
                        if (in_nan) begin
                            out_float_q <= QNAN_C;
                        end else if (in_inf) begin
                            out_float_q <= {in_sign, {EXPBITS{1'b1}}, {FRACBITS{1'b0}}};
                        end else if (mant_zero_s) begin
                            out_float_q <= {in_sign, {(FW-1){1'b0}}};
                        end
                    end
                end
                S_NORM: begin
                    if (rsh_s) begin
                        mant_q <= mant_rsh_s;
                        exp_q  <= exp_q + EXP_ONE;
                    end else if (lsh_s) begin
                        mant_q <= mant_lsh_s;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                    if (norm_cnt_q != CNT_MAX) begin
                        norm_cnt_q <= norm_cnt_q + CNT_ONE;
                    end
                end
                S_ROUND: begin
                    out_float_q <= float_r_s;
                    ovf_q       <= ovf_r_s;
                    unf_q       <= unf_r_s;
                    inx_q       <= inx_r_s;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_float = out_float_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_inx   = inx_q;

    float_normalize_round_chk #(
        .CW    (CW),
        .BOUND (BOUND)
    ) u_chk (
        .clock      (clock),
        .resetN     (resetN),
        .in_norm_i  (state_q == S_NORM),
        .norm_cnt_i (norm_cnt_q)
    );
endmodule

// File: tb/tb_float_normalize_round.sv
// Testbench for float_normalize_round: directed cases plus randomized operands
// compared against an exact-value RNE reference model.
module tb_float_normalize_round;
    localparam int MB = 28;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = 10'd0;
    logic [27:0] in_mant = 28'd0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_float;
    logic        out_ovf, out_unf, out_inx;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    float_normalize_round dut (
        .clock     (clock),
        .resetN    (resetN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inx   (out_inx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Exact value is mant * 2^(exp-153); round it RNE onto the float grid.
    task automatic model(input logic s, input int e, input logic [27:0] m,
                         input logic nan, input logic inf,
                         output logic [31:0] f, output logic ovf, output logic unf,
                         output logic inx, output int lat);
        int p, be, q, sh;
        longint n, mm;
        logic g, st, up;
        ovf = 1'b0; unf = 1'b0; inx = 1'b0;
        if (nan) begin
            f = 32'h7FC0_0000; lat = 1;
        end else if (inf) begin
            f = {s, 8'hFF, 23'd0}; lat = 1;
        end else if (m == 28'd0) begin
            f = {s, 31'd0}; lat = 1;
        end else begin
            p = 0;
            for (int i = 0; i < MB; i++) if (m[i]) p = i;
            // number of normalization shifts
            if (m[27]) lat = 2 + (((1 - e) > 1) ? (1 - e) : 1);
            else if (e < 1) lat = 2 + (1 - e);
            else if (p < 26 && e > 1) lat = 2 + (((26 - p) < (e - 1)) ? (26 - p) : (e - 1));
            else lat = 2;
            be = e + p - 26;
            q  = (be >= 1) ? be : 1;
            sh = q + 3 - e;
            mm = longint'(m);
            if (sh <= 0) begin
                n = mm << (-sh); g = 1'b0; st = 1'b0;
            end else if (sh > 60) begin
                n = 0; g = 1'b0; st = 1'b1;
            end else begin
                n  = mm >> sh;
                g  = mm[sh-1];
                st = (mm & ((64'sd1 <<< (sh - 1)) - 64'sd1)) != 64'sd0;
            end
            up  = g & (st | n[0]);
            n   = n + (up ? 64'sd1 : 64'sd0);
            inx = g | st;
            if (n >= 64'sd16777216) begin
                n = n >>> 1; q = q + 1;
            end
            if (n >= 64'sd8388608 && q >= 255) begin
                f = {s, 8'hFF, 23'd0}; ovf = 1'b1; inx = 1'b1;
            end else if (n >= 64'sd8388608) begin
                f = {s, 8'(q), n[22:0]};
            end else begin
                f = {s, 8'd0, n[22:0]}; unf = inx;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic s, input int e, input logic [27:0] m,
                          input logic nan, input logic inf, input logic [31:0] ef,
                          input logic eo, input logic eu, input logic ei,
                          input int elat, input int hold);
        int  lat;
        logic seen;
        @(negedge clock);
        chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_sign = s; in_exp = 10'(e); in_mant = m;
        in_nan = nan; in_inf = inf;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_nan = 1'b0; in_inf = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 600) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk({tag, ":seen"}, 64'(seen), 64'd1);
        chk({tag, ":lat"}, 64'(lat), 64'(elat));
        chk({tag, ":float"}, 64'(out_float), 64'(ef));
        chk({tag, ":ovf"}, 64'(out_ovf), 64'(eo));
        chk({tag, ":unf"}, 64'(out_unf), 64'(eu));
        chk({tag, ":inx"}, 64'(out_inx), 64'(ei));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, ":hold_float"}, 64'(out_float), 64'(ef));
            chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ":ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ef;
        logic        eo, eu, ei;
        int          elat, e, mode, sel, shamt;
        logic [27:0] m, r;
        logic        s, seen;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:out_float", 64'(out_float), 64'd0);
        chk("rst:flags", 64'({out_ovf, out_unf, out_inx}), 64'd0);
        resetN = 1'b1;

        // directed cases
        run_op("t1_one", 1'b0, 127, 28'h400_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 2, 0);
        run_op("t2_carry", 1'b0, 127, 28'h800_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 3, 0);
        run_op("t3_lsh", 1'b0, 130, 28'h080_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 5, 0);
        run_op("t4_rcarry", 1'b0, 127, 28'h7FF_FFFC, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 2, 0);
        run_op("t5_ovf", 1'b0, 254, 28'h800_0000, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 3, 0);
        run_op("t5_negzero", 1'b1, 0, 28'h000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 0);
        run_op("nan", 1'b1, 5, 28'h400_0000, 1'b1, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0, 1, 0);
        run_op("neginf", 1'b1, 5, 28'h400_0000, 1'b0, 1'b1, 32'hFF80_0000, 1'b0, 1'b0, 1'b0, 1, 0);
        run_op("t6_hold", 1'b1, 127, 28'h400_0000, 1'b0, 1'b0, 32'hBF80_0000, 1'b0, 1'b0, 1'b0, 2, 5);

        // reset in the middle of NORM aborts the operation
        @(negedge clock);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd130; in_mant = 28'h080_0000;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b0;
        #1;
        chk("abort:in_ready_rst", 64'(in_ready), 64'd1);
        @(negedge clock);
        resetN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("abort:no_valid", 64'(seen), 64'd0);
        chk("abort:in_ready", 64'(in_ready), 64'd1);
        chk("abort:out_float", 64'(out_float), 64'd0);

        // randomized operands against the reference model
        for (int it = 0; it < 400; it++) begin
            r     = 28'($urandom);
            mode  = int'($urandom_range(0, 3));
            shamt = int'($urandom_range(0, 27));
            case (mode)
                0: m = r;
                1: m = {2'b01, r[25:0]};
                2: m = {2'b01, r[25:0]} >> shamt;
                default: m = {2'b01, r[25:3], 3'b100};
            endcase
            e   = int'($urandom_range(0, 330)) - 40;
            s   = 1'($urandom);
            sel = int'($urandom_range(0, 19));
            model(s, e, m, sel == 0, sel == 1, ef, eo, eu, ei, elat);
            run_op("rand", s, e, m, sel == 0, sel == 1, ef, eo, eu, ei, elat, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
